// File: rtl/id_stream_pkg.sv
// Shared definitions for the Y86 streaming fetch/decode front end:
// icode constants, the "no register" nibble, the FSM state encoding and
// the instruction-length helpers.
package id_stream_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVL = 4'h2;
    localparam logic [3:0] I_IRMOVL = 4'h3;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;

    // Register nibble used when an instruction has no register byte.
    localparam logic [3:0] RNONE = 4'hF;

    // Longest Y86 instruction in bytes; the decode window is this wide.
    localparam int MAX_LEN = 6;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    // Byte length of an instruction from its icode. Invalid icodes are
    // consumed as a single byte so the error record can still be popped.
    function automatic logic [2:0] inst_len(input logic [3:0] icode);
        case (icode)
            I_HALT, I_NOP, I_RET:               inst_len = 3'd1;
            I_RRMOVL, I_OPL, I_PUSHL, I_POPL:   inst_len = 3'd2;
            I_IRMOVL, I_RMMOVL, I_MRMOVL:       inst_len = 3'd6;
            I_JXX, I_CALL:                      inst_len = 3'd5;
            default:                            inst_len = 3'd1;
        endcase
    endfunction

    // icodes C..F are not part of the instruction set.
    function automatic logic inst_invalid(input logic [3:0] icode);
        inst_invalid = (icode >= 4'hC);
    endfunction

endpackage

// File: rtl/id_stream_len_dec.sv
// Combinational icode classifier: length, which optional fields exist,
// where the constant starts and whether the icode is invalid.
module inst_len_dec
    import id_stream_pkg::*;
(
    input  logic [3:0] icode_i,
    output logic [2:0] len_o,
    output logic       has_regs_o,
    output logic       has_valc_o,
    output logic [2:0] valc_off_o,
    output logic       invalid_o
);

    // Classify the icode into its field layout.
    always_comb begin
        len_o      = inst_len(icode_i);
        invalid_o  = inst_invalid(icode_i);
        has_regs_o = 1'b0;
        has_valc_o = 1'b0;
        valc_off_o = 3'd2;
        case (icode_i)
            I_RRMOVL, I_OPL, I_PUSHL, I_POPL: begin
                has_regs_o = 1'b1;
            end
            I_IRMOVL, I_RMMOVL, I_MRMOVL: begin
                has_regs_o = 1'b1;
                has_valc_o = 1'b1;
                valc_off_o = 3'd2;
            end
            I_JXX, I_CALL: begin
                has_valc_o = 1'b1;
                valc_off_o = 3'd1;
            end
            default: begin
                has_regs_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/id_stream.sv
// Streaming Y86 fetch/decode front end. Fetch beats land in a circular
// byte buffer; the head of the buffer is decoded combinationally and
// offered as one instruction record per cycle on a valid/ready port.
//
// Handshakes: a transfer happens on a rising clock edge where both valid
// and ready are high. fetch_ready and dec_valid are functions of registered
// state plus redirect only; neither depends on its partner's valid/ready.
module id_stream
    import id_stream_pkg::*;
#(
    parameter int FETCH_BYTES = 4,
    parameter int BUF_BYTES   = 16,
    parameter int PC_W        = 16,
    parameter int WORD_W      = 32,
    parameter int RESET_PC    = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [PC_W-1:0]          fetch_addr,
    input  logic                     fetch_valid,
    output logic                     fetch_ready,
    input  logic [FETCH_BYTES*8-1:0] fetch_data,
    input  logic                     redirect,
    input  logic [PC_W-1:0]          redirect_pc,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [3:0]               icode,
    output logic [3:0]               ifun,
    output logic [3:0]               rA,
    output logic [3:0]               rB,
    output logic [WORD_W-1:0]        valC,
    output logic [PC_W-1:0]          valP,
    output logic [PC_W-1:0]          pc_o,
    output logic                     instr_err,
    output logic                     halted,
    output logic [1:0]               dbg_state_o
);

    localparam int PTR_W = $clog2(BUF_BYTES);
    localparam int CNT_W = $clog2(BUF_BYTES) + 1;

    logic [7:0]       mem_q [BUF_BYTES];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  faddr_q, faddr_d;
    state_e           state_q, state_d;

    logic [7:0]       win [MAX_LEN];
    logic [2:0]       len;
    logic             has_regs, has_valc, invalid;
    logic [2:0]       valc_off;
    logic [31:0]      valc32;
    logic             push, pop, run;
    logic [CNT_W-1:0] push_amt, pop_amt;

    // Bytes at the head of the buffer, in address order.
    always_comb begin
        for (int k = 0; k < MAX_LEN; k++) begin
            win[k] = mem_q[head_q + PTR_W'(k)];
        end
    end

    inst_len_dec u_len_dec (
        .icode_i    (win[0][7:4]),
        .len_o      (len),
        .has_regs_o (has_regs),
        .has_valc_o (has_valc),
        .valc_off_o (valc_off),
        .invalid_o  (invalid)
    );

    assign run         = (state_q == ST_RUN);
    assign fetch_ready = run && !redirect
                         && (count_q <= CNT_W'(BUF_BYTES - FETCH_BYTES));
    assign dec_valid   = run && !redirect && (count_q != '0)
                         && (count_q >= CNT_W'(len));
    assign push        = fetch_valid && fetch_ready;
    assign pop         = dec_valid && dec_ready;
    assign push_amt    = push ? CNT_W'(FETCH_BYTES) : '0;
    assign pop_amt     = pop ? CNT_W'(len) : '0;

    assign fetch_addr  = faddr_q;
    assign halted      = !run;
    assign dbg_state_o = state_q;

    // Little-endian constant picked from the decode window.
    always_comb begin
        valc32 = '0;
        if (has_valc) begin
            if (valc_off == 3'd1) valc32 = {win[4], win[3], win[2], win[1]};
            else                  valc32 = {win[5], win[4], win[3], win[2]};
        end
    end

    // Record outputs, forced to zero whenever no record is offered.
    always_comb begin
        icode     = '0;
        ifun      = '0;
        rA        = '0;
        rB        = '0;
        valC      = '0;
        valP      = '0;
        pc_o      = '0;
        instr_err = 1'b0;
        if (dec_valid) begin
            icode     = win[0][7:4];
            ifun      = win[0][3:0];
            rA        = has_regs ? win[1][7:4] : RNONE;
            rB        = has_regs ? win[1][3:0] : RNONE;
            valC      = WORD_W'(valc32);
            valP      = pc_q + PC_W'(len);
            pc_o      = pc_q;
            instr_err = invalid;
        end
    end

    // Next-state for pointers, PC and FSM; redirect overrides push and pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pc_d    = pc_q;
        faddr_d = faddr_q;
        state_d = state_q;
        if (redirect) begin
            head_d  = tail_q;
            count_d = '0;
            pc_d    = redirect_pc;
            faddr_d = redirect_pc;
            state_d = ST_RUN;
        end else begin
            if (push) begin
                tail_d  = tail_q + PTR_W'(FETCH_BYTES);
                faddr_d = faddr_q + PC_W'(FETCH_BYTES);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(len);
                pc_d   = pc_q + PC_W'(len);
                if (invalid)                    state_d = ST_ERR;
                else if (win[0][7:4] == I_HALT) state_d = ST_HALT;
            end
            count_d = count_q + push_amt - pop_amt;
        end
    end

    // Control registers and FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pc_q    <= PC_W'(RESET_PC);
            faddr_q <= PC_W'(RESET_PC);
            state_q <= ST_RUN;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            faddr_q <= faddr_d;
            state_q <= state_d;
        end
    end

    // Byte storage; contents only matter where count says they are live.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            for (int i = 0; i < FETCH_BYTES; i++) begin
                mem_q[tail_q + PTR_W'(i)] <= fetch_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_id_stream.sv
// Directed bench for id_stream: a byte-addressed memory answers fetch
// requests, and each step checks hand-computed record fields.
module tb_id_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] fetch_addr;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [31:0] valC;
    logic [15:0] valP, pc_o;
    logic        instr_err, halted;
    logic [1:0]  dbg_state;

    int passes = 0;
    int checks = 0;
    logic [15:0] fa_hold;

    logic [7:0] mem [0:65535];

    always #5 clk = ~clk;

    assign fetch_data = {mem[fetch_addr + 16'd3], mem[fetch_addr + 16'd2],
                         mem[fetch_addr + 16'd1], mem[fetch_addr]};

    id_stream #(
        .FETCH_BYTES(4), .BUF_BYTES(16), .PC_W(16), .WORD_W(32), .RESET_PC(0)
    ) dut (
        .clk(clk), .rst(rst),
        .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
        .fetch_ready(fetch_ready), .fetch_data(fetch_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP), .pc_o(pc_o),
        .instr_err(instr_err), .halted(halted), .dbg_state_o(dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !dec_valid; i++) step();
        chk(tag, {31'd0, dec_valid}, 32'd1);
    endtask

    task automatic accept();
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
    endtask

    task automatic do_redirect(input logic [15:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        #1;
        chk("redir_dec_valid_low", {31'd0, dec_valid}, 32'd0);
        chk("redir_fetch_ready_low", {31'd0, fetch_ready}, 32'd0);
        step();
        redirect = 1'b0;
        chk("redir_fetch_addr", {16'd0, fetch_addr}, {16'd0, pc});
    endtask

    initial begin
        rst = 1'b1; fetch_valid = 1'b0; dec_ready = 1'b0;
        redirect = 1'b0; redirect_pc = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h10;
        // 0x0000: IRMOVL $0x01020304,%edx ; NOP ; HALT
        mem[0] = 8'h30; mem[1] = 8'hF2; mem[2] = 8'h04; mem[3] = 8'h03;
        mem[4] = 8'h02; mem[5] = 8'h01; mem[6] = 8'h10; mem[7] = 8'h00;
        // 0x0100: JXX 0x00000020
        mem[16'h0100] = 8'h70; mem[16'h0101] = 8'h20; mem[16'h0102] = 8'h00;
        mem[16'h0103] = 8'h00; mem[16'h0104] = 8'h00;
        // 0x0200: invalid icode
        mem[16'h0200] = 8'hC0;

        // Reset state
        step(); step();
        chk("rst_fetch_addr", {16'd0, fetch_addr}, 32'd0);
        chk("rst_pc_o", {16'd0, pc_o}, 32'd0);
        chk("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
        chk("rst_fetch_ready", {31'd0, fetch_ready}, 32'd1);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b0;
        fetch_valid = 1'b1;

        // IRMOVL / NOP / HALT
        wait_valid("irmovl_valid");
        chk("irmovl_icode", {28'd0, icode}, 32'd3);
        chk("irmovl_ifun", {28'd0, ifun}, 32'd0);
        chk("irmovl_rA", {28'd0, rA}, 32'hF);
        chk("irmovl_rB", {28'd0, rB}, 32'd2);
        chk("irmovl_valC", valC, 32'h01020304);
        chk("irmovl_pc", {16'd0, pc_o}, 32'd0);
        chk("irmovl_valP", {16'd0, valP}, 32'd6);
        chk("irmovl_err", {31'd0, instr_err}, 32'd0);
        accept();
        wait_valid("nop_valid");
        chk("nop_icode", {28'd0, icode}, 32'd1);
        chk("nop_rA", {28'd0, rA}, 32'hF);
        chk("nop_rB", {28'd0, rB}, 32'hF);
        chk("nop_valC", valC, 32'd0);
        chk("nop_pc", {16'd0, pc_o}, 32'd6);
        chk("nop_valP", {16'd0, valP}, 32'd7);
        accept();
        wait_valid("halt_valid");
        chk("halt_icode", {28'd0, icode}, 32'd0);
        chk("halt_pc", {16'd0, pc_o}, 32'd7);
        chk("halt_valP", {16'd0, valP}, 32'd8);
        chk("halt_not_yet", {31'd0, halted}, 32'd0);
        accept();
        fa_hold = fetch_addr;
        step(); step(); step();
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_state", {30'd0, dbg_state}, 32'd1);
        chk("halt_fetch_ready", {31'd0, fetch_ready}, 32'd0);
        chk("halt_dec_valid", {31'd0, dec_valid}, 32'd0);
        chk("halt_no_fetch", {16'd0, fetch_addr}, {16'd0, fa_hold});

        // JXX leaves HALT via redirect
        do_redirect(16'h0100);
        chk("jxx_left_halt", {31'd0, halted}, 32'd0);
        wait_valid("jxx_valid");
        chk("jxx_icode", {28'd0, icode}, 32'd7);
        chk("jxx_rA", {28'd0, rA}, 32'hF);
        chk("jxx_rB", {28'd0, rB}, 32'hF);
        chk("jxx_valC", valC, 32'h00000020);
        chk("jxx_pc", {16'd0, pc_o}, 32'h0100);
        chk("jxx_valP", {16'd0, valP}, 32'h0105);
        accept();

        // Invalid icode -> ERR
        do_redirect(16'h0200);
        wait_valid("err_valid");
        chk("err_flag", {31'd0, instr_err}, 32'd1);
        chk("err_icode", {28'd0, icode}, 32'hC);
        chk("err_valP", {16'd0, valP}, 32'h0201);
        accept();
        fa_hold = fetch_addr;
        step(); step(); step();
        chk("err_state", {30'd0, dbg_state}, 32'd2);
        chk("err_halted", {31'd0, halted}, 32'd1);
        chk("err_fetch_ready", {31'd0, fetch_ready}, 32'd0);
        chk("err_dec_valid", {31'd0, dec_valid}, 32'd0);
        chk("err_no_fetch", {16'd0, fetch_addr}, {16'd0, fa_hold});

        // Back-pressure on a NOP stream
        do_redirect(16'h0300);
        step();
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", {31'd0, dec_valid}, 32'd1);
            chk("stall_pc_stable", {16'd0, pc_o}, 32'h0300);
            chk("stall_valP_stable", {16'd0, valP}, 32'h0301);
            step();
        end
        chk("stall_fetch_ready", {31'd0, fetch_ready}, 32'd0);
        chk("stall_fetch_addr", {16'd0, fetch_addr}, 32'h0310);
        dec_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("drain_valid", {31'd0, dec_valid}, 32'd1);
            chk("drain_pc", {16'd0, pc_o}, 32'h0300 + 32'(i));
            step();
        end
        dec_ready = 1'b0;

        // Redirect with 9 buffered bytes and a pop pending
        do_redirect(16'h0400);
        step(); step(); step();
        fetch_valid = 1'b0;
        dec_ready = 1'b1;
        step(); step(); step();
        dec_ready = 1'b0;
        chk("pend_valid", {31'd0, dec_valid}, 32'd1);
        chk("pend_pc", {16'd0, pc_o}, 32'h0403);
        chk("pend_fetch_addr", {16'd0, fetch_addr}, 32'h040C);
        dec_ready = 1'b1;
        do_redirect(16'h0040);
        dec_ready = 1'b0;
        chk("flush_empty", {31'd0, dec_valid}, 32'd0);
        fetch_valid = 1'b1;
        wait_valid("flush_first_valid");
        chk("flush_first_pc", {16'd0, pc_o}, 32'h0040);
        chk("flush_first_valP", {16'd0, valP}, 32'h0041);

        // PC wrap with OPL stream
        mem[16'hFFFE] = 8'h60; mem[16'hFFFF] = 8'h12;
        for (int i = 0; i < 8; i += 2) begin
            mem[i] = 8'h60; mem[i+1] = 8'h12;
        end
        do_redirect(16'hFFFE);
        wait_valid("wrap_valid");
        chk("wrap_icode", {28'd0, icode}, 32'd6);
        chk("wrap_rA", {28'd0, rA}, 32'd1);
        chk("wrap_rB", {28'd0, rB}, 32'd2);
        chk("wrap_pc", {16'd0, pc_o}, 32'hFFFE);
        chk("wrap_valP", {16'd0, valP}, 32'h0000);
        chk("wrap_fetch_addr", {16'd0, fetch_addr}, 32'h0002);
        accept();
        chk("wrap_next_pc", {16'd0, pc_o}, 32'h0000);
        chk("wrap_next_valP", {16'd0, valP}, 32'h0002);

        // Reset mid-stream discards buffered bytes
        rst = 1'b1;
        step();
        chk("rst2_dec_valid", {31'd0, dec_valid}, 32'd0);
        chk("rst2_fetch_addr", {16'd0, fetch_addr}, 32'd0);
        rst = 1'b0;
        wait_valid("rst2_valid");
        chk("rst2_pc", {16'd0, pc_o}, 32'd0);
        chk("rst2_icode", {28'd0, icode}, 32'd6);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
